// File: rtl/fp16_pkg.sv
// Shared FP16 constants, the add-stage state encoding and the effective-exponent helper.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam int SIG_W  = 11;
    localparam int GRS_W  = 3;
    localparam int WORK_W = SIG_W + GRS_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } add_state_t;

    // Denormals share the exponent of the smallest normal, so a zero field behaves as 1.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

endpackage

// File: rtl/align_add_stage_sticky_shifter.sv
// Combinational right shifter by 0..MAX_STEP bits.
// Every bit pushed off the bottom is ORed into the LSB, so a later rounder still
// sees that something non-zero was lost.
module sticky_shifter
    import fp16_pkg::*;
#(
    parameter int WIDTH    = WORK_W,
    parameter int MAX_STEP = 1,
    parameter int AMT_W    = $clog2(MAX_STEP + 1)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] lost_mask;
    logic             lost_any;

    // Shift, then fold any discarded bits into the sticky position.
    always_comb begin
        lost_mask = (WIDTH'(1) << amt) - WIDTH'(1);
        lost_any  = |(din & lost_mask);
        dout      = (din >> amt) | {{(WIDTH-1){1'b0}}, lost_any};
    end

endmodule

// File: rtl/align_add_stage.sv
// FP16 align/add stage.
// Takes an operand pair that has already been ordered by exponent. The smaller
// operand is aligned a few bits per cycle through the sticky shifter, then the
// two operands are added or subtracted. The result is an unnormalised
// significand that carries guard/round/sticky bits for the normalise/round stage.
// Only one operation is in flight at a time.
module align_add_stage
    import fp16_pkg::*;
#(
    parameter int SHIFT_STEP = 1,
    parameter int MAX_SHIFT  = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign_l,
    input  logic             sign_s,
    input  logic [EXP_W-1:0] exp_l,
    input  logic [EXP_W-1:0] exp_s,
    input  logic [MAN_W-1:0] man_l,
    input  logic [MAN_W-1:0] man_s,
    input  logic             swap,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WORK_W:0]  sum,
    output logic [EXP_W-1:0] exp_o,
    output logic             sign_o,
    output logic             zero_o,
    output logic             swap_o
);

    localparam int CNT_W = $clog2(MAX_SHIFT + 1);
    localparam int AMT_W = $clog2(SHIFT_STEP + 1);

    add_state_t        state_q, state_d;
    logic [WORK_W-1:0] l_q, l_d;
    logic [WORK_W-1:0] s_q, s_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [EXP_W-1:0]  eexp_l_q, eexp_l_d;
    logic              sign_l_q, sign_l_d;
    logic              sign_s_q, sign_s_d;
    logic              swap_in_q, swap_in_d;

    logic              out_valid_q, out_valid_d;
    logic [WORK_W:0]   sum_q, sum_d;
    logic [EXP_W-1:0]  exp_o_q, exp_o_d;
    logic              sign_o_q, sign_o_d;
    logic              zero_o_q, zero_o_d;
    logic              swap_o_q, swap_o_d;

    logic [EXP_W-1:0]  eexp_l_in, eexp_s_in;
    logic [EXP_W:0]    shift_diff;
    logic [CNT_W-1:0]  shift_sat;
    logic [CNT_W-1:0]  step_cnt;
    logic [WORK_W-1:0] s_shifted;
    logic [WORK_W:0]   add_res;
    logic [WORK_W:0]   sub_res;
    logic [WORK_W:0]   sub_mag;
    logic              sub_neg;
    logic [WORK_W:0]   res_mag;
    logic              res_sign;

    // Incoming alignment distance; a negative difference would be an upstream
    // ordering error and is treated as no shift at all.
    always_comb begin
        eexp_l_in  = eff_exp(exp_l);
        eexp_s_in  = eff_exp(exp_s);
        shift_diff = {1'b0, eexp_l_in} - {1'b0, eexp_s_in};
        if (shift_diff[EXP_W]) begin
            shift_sat = '0;
        end else if (shift_diff >= (EXP_W+1)'(MAX_SHIFT)) begin
            shift_sat = CNT_W'(MAX_SHIFT);
        end else begin
            shift_sat = shift_diff[CNT_W-1:0];
        end
    end

    // The last alignment step may be shorter than SHIFT_STEP.
    always_comb begin
        step_cnt = (rem_q < CNT_W'(SHIFT_STEP)) ? rem_q : CNT_W'(SHIFT_STEP);
    end

    sticky_shifter #(
        .WIDTH    (WORK_W),
        .MAX_STEP (SHIFT_STEP),
        .AMT_W    (AMT_W)
    ) u_shifter (
        .din  (s_q),
        .amt  (step_cnt[AMT_W-1:0]),
        .dout (s_shifted)
    );

    // Significand add/subtract; a negative difference flips to magnitude and takes S's sign.
    always_comb begin
        add_res = {1'b0, l_q} + {1'b0, s_q};
        sub_res = {1'b0, l_q} - {1'b0, s_q};
        sub_neg = sub_res[WORK_W];
        sub_mag = sub_neg ? (~sub_res + (WORK_W+1)'(1)) : sub_res;
        if (sign_l_q ^ sign_s_q) begin
            res_mag  = sub_mag;
            res_sign = sub_neg ? sign_s_q : sign_l_q;
        end else begin
            res_mag  = add_res;
            res_sign = sign_l_q;
        end
    end

    // Next-state and datapath update for the IDLE -> ALIGN -> ADD -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        l_d         = l_q;
        s_d         = s_q;
        rem_d       = rem_q;
        eexp_l_d    = eexp_l_q;
        sign_l_d    = sign_l_q;
        sign_s_d    = sign_s_q;
        swap_in_d   = swap_in_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        exp_o_d     = exp_o_q;
        sign_o_d    = sign_o_q;
        zero_o_d    = zero_o_q;
        swap_o_d    = swap_o_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    l_d       = {(exp_l != '0), man_l, {GRS_W{1'b0}}};
                    s_d       = {(exp_s != '0), man_s, {GRS_W{1'b0}}};
                    rem_d     = shift_sat;
                    eexp_l_d  = eexp_l_in;
                    sign_l_d  = sign_l;
                    sign_s_d  = sign_s;
                    swap_in_d = swap;
                    state_d   = (shift_sat != '0) ? ALIGN : ADD;
                end
            end
            ALIGN: begin
                s_d   = s_shifted;
                rem_d = rem_q - step_cnt;
                if (rem_q == step_cnt) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d       = res_mag;
                exp_o_d     = eexp_l_q;
                zero_o_d    = (res_mag == '0);
                sign_o_d    = (res_mag == '0) ? 1'b0 : res_sign;
                swap_o_d    = swap_in_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any operation in flight and clears the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            l_q         <= '0;
            s_q         <= '0;
            rem_q       <= '0;
            eexp_l_q    <= '0;
            sign_l_q    <= 1'b0;
            sign_s_q    <= 1'b0;
            swap_in_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            exp_o_q     <= '0;
            sign_o_q    <= 1'b0;
            zero_o_q    <= 1'b0;
            swap_o_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            l_q         <= l_d;
            s_q         <= s_d;
            rem_q       <= rem_d;
            eexp_l_q    <= eexp_l_d;
            sign_l_q    <= sign_l_d;
            sign_s_q    <= sign_s_d;
            swap_in_q   <= swap_in_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            exp_o_q     <= exp_o_d;
            sign_o_q    <= sign_o_d;
            zero_o_q    <= zero_o_d;
            swap_o_q    <= swap_o_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign exp_o     = exp_o_q;
    assign sign_o    = sign_o_q;
    assign zero_o    = zero_o_q;
    assign swap_o    = swap_o_q;

endmodule

// File: tb/tb_align_add_stage.sv
// Directed bench for align_add_stage: hand-computed FP16 add/sub cases,
// backpressure hold, reset during alignment and a denormal operand.
module tb_align_add_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_l;
    logic        sign_s;
    logic [4:0]  exp_l;
    logic [4:0]  exp_s;
    logic [9:0]  man_l;
    logic [9:0]  man_s;
    logic        swap;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] sum;
    logic [4:0]  exp_o;
    logic        sign_o;
    logic        zero_o;
    logic        swap_o;

    int vectors    = 0;
    int miscompares = 0;
    int lat;
    logic [14:0] held_sum;

    align_add_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_l    (sign_l),
        .sign_s    (sign_s),
        .exp_l     (exp_l),
        .exp_s     (exp_s),
        .man_l     (man_l),
        .man_s     (man_s),
        .swap      (swap),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .exp_o     (exp_o),
        .sign_o    (sign_o),
        .zero_o    (zero_o),
        .swap_o    (swap_o)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // out_valid and in_ready must never be high together.
    always @(negedge clk) begin
        vectors++;
        assert (!(out_valid === 1'b1 && in_ready === 1'b1)) else begin
            miscompares++;
            $error("[TB] FAIL excl: observed out_valid=%0b in_ready=%0b required not both 1", out_valid, in_ready);
        end
    end

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one operand pair, handshake, then count edges until out_valid appears.
    task automatic applyStimulus(input logic sl, input logic ss, input logic [4:0] el, input logic [4:0] es,
                                 input logic [9:0] ml, input logic [9:0] ms, input logic sw,
                                 output int latency);
        @(negedge clk);
        sign_l   = sl;
        sign_s   = ss;
        exp_l    = el;
        exp_s    = es;
        man_l    = ml;
        man_s    = ms;
        swap     = sw;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        latency  = 1;
        while (out_valid !== 1'b1 && latency < 100) begin
            @(posedge clk);
            #1;
            latency++;
        end
        @(negedge clk);
    endtask

    // Compare every result field, then retire the result.
    task automatic checkResult(input string tag, input logic [14:0] e_sum, input logic [4:0] e_exp,
                               input logic e_sign, input logic e_zero, input logic e_swap,
                               input int e_lat, input int got_lat);
        checkOutput({tag, ".lat"},   16'(got_lat), 16'(e_lat));
        checkOutput({tag, ".valid"}, 16'(out_valid), 16'h1);
        checkOutput({tag, ".sum"},   16'(sum),    16'(e_sum));
        checkOutput({tag, ".exp"},   16'(exp_o),  16'(e_exp));
        checkOutput({tag, ".sign"},  16'(sign_o), 16'(e_sign));
        checkOutput({tag, ".zero"},  16'(zero_o), 16'(e_zero));
        checkOutput({tag, ".swap"},  16'(swap_o), 16'(e_swap));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, ".ret_valid"}, 16'(out_valid), 16'h0);
        checkOutput({tag, ".ret_ready"}, 16'(in_ready),  16'h1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sign_l    = 1'b0;
        sign_s    = 1'b0;
        exp_l     = '0;
        exp_s     = '0;
        man_l     = '0;
        man_s     = '0;
        swap      = 1'b0;
        $display("[TB] start");

        repeat (3) @(negedge clk);
        checkOutput("rst.valid", 16'(out_valid), 16'h0);
        checkOutput("rst.sum",   16'(sum),       16'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst.ready", 16'(in_ready), 16'h1);
        checkOutput("rst.exp",   16'(exp_o),    16'h0);
        checkOutput("rst.sign",  16'(sign_o),   16'h0);
        checkOutput("rst.zero",  16'(zero_o),   16'h0);
        checkOutput("rst.swap",  16'(swap_o),   16'h0);

        // 1.0 + 1.0
        applyStimulus(1'b0, 1'b0, 5'd15, 5'd15, 10'h000, 10'h000, 1'b0, lat);
        checkResult("one_plus_one", 15'h4000, 5'd15, 1'b0, 1'b0, 1'b0, 2, lat);

        // 1.0 + 0.125: three single-bit alignment cycles
        applyStimulus(1'b0, 1'b0, 5'd15, 5'd12, 10'h000, 10'h000, 1'b1, lat);
        checkResult("one_plus_eighth", 15'h2400, 5'd15, 1'b0, 1'b0, 1'b1, 5, lat);

        // +1.5 + -1.5 cancels exactly
        applyStimulus(1'b0, 1'b1, 5'd15, 5'd15, 10'h200, 10'h200, 1'b0, lat);
        checkResult("cancel", 15'h0000, 5'd15, 1'b0, 1'b1, 1'b0, 2, lat);

        // +1.25 - 1.5: negative difference takes S's sign
        applyStimulus(1'b0, 1'b1, 5'd15, 5'd15, 10'h100, 10'h200, 1'b0, lat);
        checkResult("neg_diff", 15'h0800, 5'd15, 1'b1, 1'b0, 1'b0, 2, lat);

        // Shift of 29 saturates at 14, S collapses to sticky only
        applyStimulus(1'b0, 1'b0, 5'd30, 5'd1, 10'h000, 10'h000, 1'b0, lat);
        checkResult("saturate", 15'h2001, 5'd30, 1'b0, 1'b0, 1'b0, 16, lat);

        // Shift of 4 loses a one bit: 0x2018 -> 0x0201, 0x2000 - 0x0201 = 0x1DFF
        applyStimulus(1'b0, 1'b1, 5'd15, 5'd11, 10'h000, 10'h003, 1'b0, lat);
        checkResult("sticky_sub", 15'h1DFF, 5'd15, 1'b0, 1'b0, 1'b0, 6, lat);

        // 2.0 + 1.5 held under backpressure for 10 cycles
        applyStimulus(1'b0, 1'b0, 5'd16, 5'd15, 10'h000, 10'h200, 1'b1, lat);
        held_sum = sum;
        checkOutput("bp.first_sum", 16'(held_sum), 16'h3800);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp.valid", 16'(out_valid), 16'h1);
            checkOutput("bp.ready", 16'(in_ready),  16'h0);
            checkOutput("bp.sum",   16'(sum),       16'h3800);
        end
        checkResult("backpressure", 15'h3800, 5'd16, 1'b0, 1'b0, 1'b1, 3, lat);

        // Reset in the middle of a long alignment
        @(negedge clk);
        sign_l   = 1'b0;
        sign_s   = 1'b0;
        exp_l    = 5'd30;
        exp_s    = 5'd1;
        man_l    = 10'h000;
        man_s    = 10'h000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("abort.busy", 16'(in_ready), 16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort.valid", 16'(out_valid), 16'h0);
        checkOutput("abort.sum",   16'(sum),       16'h0);
        checkOutput("abort.exp",   16'(exp_o),     16'h0);
        checkOutput("abort.swap",  16'(swap_o),    16'h0);
        checkOutput("abort.ready", 16'(in_ready),  16'h1);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("abort.dropped", 16'(out_valid), 16'h0);

        // 1.0 - 0.5 after the abort
        applyStimulus(1'b0, 1'b1, 5'd15, 5'd14, 10'h000, 10'h000, 1'b0, lat);
        checkResult("after_abort", 15'h1000, 5'd15, 1'b0, 1'b0, 1'b0, 3, lat);

        // Denormal S with exp_l=1: both effective exponents are 1, no alignment
        applyStimulus(1'b0, 1'b0, 5'd1, 5'd0, 10'h001, 10'h3FF, 1'b0, lat);
        checkResult("denormal", 15'h4000, 5'd1, 1'b0, 1'b0, 1'b0, 2, lat);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
